// File: rtl/clken_gen.sv
// Lock-aware reset sequencer with per-channel fractional clock-enable strobes.
// Optional CLKEN_GEN_LOCK_FILTER_EN: lock loss needs 4 consecutive synced-low cycles.
`timescale 1ns/1ps
module clken_gen #(
    parameter int unsigned NUM_CLOCKS  = 2,
    parameter int unsigned ACC_WIDTH   = 24,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned STAGGER     = 16
) (
    input  logic                            refclk,
    input  logic                            rst,
    input  logic                            locked,
    input  logic [NUM_CLOCKS*ACC_WIDTH-1:0] inc,
    input  logic                            inc_load,
    output logic [NUM_CLOCKS-1:0]           clken,
    output logic [NUM_CLOCKS-1:0]           rst_out,
    output logic                            ready
);

    localparam int unsigned REL_END = STAGGER * NUM_CLOCKS;
    localparam int unsigned CNT_MAX = (LOCK_CYCLES > REL_END) ? LOCK_CYCLES : REL_END;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {StWaitLock, StSettle, StRelease, StRun} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CLOCKS-1:0]   rst_out_q, rst_out_d;
    logic                    ready_q, ready_d;
    logic [NUM_CLOCKS-1:0]   clken_q;
    logic [1:0]              lock_sync_q;
    logic                    lock_s;
    logic                    lock_lost;
    logic                    lock_drop;

    logic [ACC_WIDTH-1:0]    shadow_q [NUM_CLOCKS];
    logic [ACC_WIDTH-1:0]    acc_q    [NUM_CLOCKS];
    logic [ACC_WIDTH:0]      sum      [NUM_CLOCKS];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_sync_q <= 2'b00;
        end else begin
            lock_sync_q <= {lock_sync_q[0], locked};
        end
    end

    assign lock_s = lock_sync_q[1];

`ifdef CLKEN_GEN_LOCK_FILTER_EN
    logic [1:0] low_cnt_q;

    // Saturating run length of synced-low samples; the 4th low sample is a real loss.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            low_cnt_q <= 2'd0;
        end else if (lock_s) begin
            low_cnt_q <= 2'd0;
        end else if (low_cnt_q != 2'd3) begin
            low_cnt_q <= low_cnt_q + 2'd1;
        end
    end

    assign lock_lost = !lock_s && (low_cnt_q == 2'd3);
`else
    assign lock_lost = !lock_s;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        lock_drop = 1'b0;
        case (state_q)
            StWaitLock: begin
                if (lock_s) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (lock_lost) begin
                    lock_drop = 1'b1;
                end else if (lock_s) begin
                    if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_d = StRelease;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRelease: begin
                if (lock_lost) begin
                    lock_drop = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
                        if (cnt_d == CNT_W'(STAGGER * (i + 1))) begin
                            rst_out_d[i] = 1'b0;
                        end
                    end
                    if (cnt_d == CNT_W'(REL_END)) begin
                        state_d = StRun;
                        ready_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (lock_lost) begin
                    lock_drop = 1'b1;
                end
            end
            default: state_d = StWaitLock;
        endcase
        if (lock_drop) begin
            state_d   = StWaitLock;
            cnt_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= StWaitLock;
            cnt_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
            sum[i] = {1'b0, acc_q[i]} + {1'b0, shadow_q[i]};
        end
    end

    // inc_load zeroes every accumulator together so related increments stay phase-aligned.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
                shadow_q[i] <= '0;
                acc_q[i]    <= '0;
            end
            clken_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
                if (inc_load) begin
                    shadow_q[i] <= inc[i*ACC_WIDTH +: ACC_WIDTH];
                end
                if (inc_load || lock_drop || rst_out_q[i]) begin
                    acc_q[i]   <= '0;
                    clken_q[i] <= 1'b0;
                end else begin
                    acc_q[i]   <= sum[i][ACC_WIDTH-1:0];
                    clken_q[i] <= sum[i][ACC_WIDTH];
                end
            end
        end
    end

    assign clken   = clken_q;
    assign rst_out = rst_out_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_clken_gen.sv
// Directed self-checking bench for clken_gen (2 channels, 8-bit accumulators).
`timescale 1ns/1ps
module tb_clken_gen;

    localparam int unsigned NC = 2;
    localparam int unsigned AW = 8;

    logic            refclk = 1'b0;
    logic            rst;
    logic            locked;
    logic [NC*AW-1:0] inc;
    logic            inc_load;
    logic [NC-1:0]   clken;
    logic [NC-1:0]   rst_out;
    logic            ready;

    int checks   = 0;
    int failures = 0;

    always #5 refclk = ~refclk;

    clken_gen #(
        .NUM_CLOCKS (NC),
        .ACC_WIDTH  (AW),
        .LOCK_CYCLES(16),
        .STAGGER    (4)
    ) dut (
        .refclk  (refclk),
        .rst     (rst),
        .locked  (locked),
        .inc     (inc),
        .inc_load(inc_load),
        .clken   (clken),
        .rst_out (rst_out),
        .ready   (ready)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] e;
        int c0;
        int c1;

        rst = 1'b1; locked = 1'b0; inc_load = 1'b0; inc = '0;
        tick(2);
        check("reset_clken", 32'(clken), 32'h0);
        check("reset_rst_out", 32'(rst_out), 32'h3);
        check("reset_ready", 32'(ready), 32'h0);

        // Load ch0=0x40, ch1=0x80 before lock, then raise lock (edge 1 is the next posedge).
        rst = 1'b0; inc = {8'h80, 8'h40}; inc_load = 1'b1;
        tick(1);
        inc_load = 1'b0; locked = 1'b1;
        tick(22);
        check("seq_rst_out_e22", 32'(rst_out), 32'h3);
        tick(1);
        check("seq_rst_out_e23", 32'(rst_out), 32'h2);
        check("seq_ready_e23", 32'(ready), 32'h0);
        tick(3);
        check("seq_rst_out_e26", 32'(rst_out), 32'h2);
        check("seq_ready_e26", 32'(ready), 32'h0);
        tick(1);
        check("seq_rst_out_e27", 32'(rst_out), 32'h0);
        check("seq_ready_e27", 32'(ready), 32'h1);
        check("seq_clken_e27", 32'(clken), 32'h1);

        // ch0 carries on edges 27,31,..; ch1 on odd edges from 29.
        for (int k = 28; k < 45; k++) begin
            tick(1);
            e[1] = (k % 2 == 1);
            e[0] = (k % 4 == 3);
            check("run_clken", 32'(clken), 32'(e));
        end

        // Mid-phase inc_load: accumulators hold 0x40/0x80 here, so a missing clear shows up.
        inc_load = 1'b1;
        tick(1);
        check("load_clken_l0", 32'(clken), 32'h0);
        inc_load = 1'b0;
        tick(1);
        check("load_clken_l1", 32'(clken), 32'h0);
        tick(1);
        check("load_clken_l2", 32'(clken), 32'h2);
        tick(1);
        check("load_clken_l3", 32'(clken), 32'h0);
        tick(1);
        check("load_clken_l4", 32'(clken), 32'h3);

        // One-cycle lock glitch.
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(1);
        check("glitch_ready_a2", 32'(ready), 32'h1);
        check("glitch_rst_out_a2", 32'(rst_out), 32'h0);
        tick(1);
`ifndef CLKEN_GEN_LOCK_FILTER_EN
        check("loss_rst_out", 32'(rst_out), 32'h3);
        check("loss_ready", 32'(ready), 32'h0);
        check("loss_clken", 32'(clken), 32'h0);
`else
        check("filt_rst_out", 32'(rst_out), 32'h0);
        check("filt_ready", 32'(ready), 32'h1);
        locked = 1'b0;
        tick(4);
        locked = 1'b1;
        tick(1);
        check("filt_ready_b5", 32'(ready), 32'h1);
        tick(1);
        check("filt_loss_rst_out", 32'(rst_out), 32'h3);
        check("filt_loss_ready", 32'(ready), 32'h0);
`endif
        // Restarted sequence: rst_out[0] drops 21 edges from here.
        tick(20);
        check("restart_rst_out_pre", 32'(rst_out), 32'h3);
        tick(1);
        check("restart_rst_out_rel0", 32'(rst_out), 32'h2);

        // Asynchronous reset in RELEASE.
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", 32'(rst_out), 32'h3);
        check("async_clken", 32'(clken), 32'h0);
        check("async_ready", 32'(ready), 32'h0);

        // ch0=0xFF, ch1=0x00.
        inc = {8'h00, 8'hFF};
        tick(1);
        rst = 1'b0; inc_load = 1'b1;
        tick(1);
        inc_load = 1'b0;
        tick(23);
        check("ff_clken_e24", 32'(clken), 32'h0);
        check("ff_rst_out_e24", 32'(rst_out), 32'h2);
        tick(1);
        check("ff_clken_e25", 32'(clken), 32'h1);
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 256; k++) begin
            tick(1);
            c0 += int'(clken[0]);
            c1 += int'(clken[1]);
        end
        check("ff_ch0_count", 32'(c0), 32'd255);
        check("zero_ch1_count", 32'(c1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
